// File: rtl/comm_switch_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// comm_switch_scheduler
//
// Shares one commutator switch driver between N_REQ timing channels. Rising
// edges on req[] are latched into pending[]. Pending requests are granted one
// at a time in round-robin order. Each grant issues a start strobe, then waits
// for drv_done or a timeout, then holds a guard gap before the next grant.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-low reset
//   req          per-channel request level; a rising edge is one request
//   drv_busy     driver not ready (level, sampled only while idle)
//   drv_done     driver completion strobe (honoured only while waiting)
//   cmd_start    one-clock start strobe to the driver
//   cmd_ch       channel of the current/last command
//   pending      latched requests not yet granted
//   ena          high from cmd_start until the guard gap ends
//   err_timeout  one-clock strobe when the driver fails to complete in time
//   drop_cnt     saturating count of requests merged into a pending bit
// -----------------------------------------------------------------------------
module comm_switch_scheduler #(
    parameter int N_REQ       = 4,
    parameter int CH_W        = 2,
    parameter int GUARD_CYC   = 20,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             drv_busy,
    input  logic             drv_done,
    output logic             cmd_start,
    output logic [CH_W-1:0]  cmd_ch,
    output logic [N_REQ-1:0] pending,
    output logic             ena,
    output logic             err_timeout,
    output logic [7:0]       drop_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GUARD_CYC + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0]   GRD_LAST = GW'(GUARD_CYC - 1);
    localparam logic [CH_W-1:0] RR_INIT  = CH_W'(N_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GUARD} state_t;

    state_t           r_state, w_state_nx;
    logic [N_REQ-1:0] r_req_d, r_pending;
    logic [N_REQ-1:0] w_edge, w_clr, w_drop;
    logic [CH_W-1:0]  r_rr_ptr, r_cmd_ch, w_sel, w_hi_sel, w_lo_sel;
    logic             w_hi_found;
    logic [TW-1:0]    r_tmo_cnt;
    logic [GW-1:0]    r_gcnt;
    logic [7:0]       r_drop_cnt;
    logic [3:0]       w_drop_n;
    logic [8:0]       w_drop_sum;
    logic             r_cmd_start, r_ena, r_err;
    logic             w_grant, w_timeout, w_to_guard, w_to_idle;

    assign w_edge = req & ~r_req_d;
    assign w_clr  = w_grant ? (N_REQ'(1) << w_sel) : '0;
    // An edge on a bit that is being granted this cycle re-arms it, so it is
    // not a merge and is not counted.
    assign w_drop = w_edge & r_pending & ~w_clr;

    // Round-robin pick: lowest pending index above rr_ptr, otherwise the
    // lowest pending index overall (the wrap-around half of the search).
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_sel   = '0;
        w_lo_sel   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                if (CH_W'(i) > r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_sel   = CH_W'(i);
                end else begin
                    w_lo_sel   = CH_W'(i);
                end
            end
        end
        w_sel = w_hi_found ? w_hi_sel : w_lo_sel;
    end

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_drop_n = w_drop_n + {3'b000, w_drop[i]};
        end
        w_drop_sum = {1'b0, r_drop_cnt} + {5'b00000, w_drop_n};
    end

    // Next-state and control decode.
    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        w_timeout  = 1'b0;
        w_to_guard = 1'b0;
        w_to_idle  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((|r_pending) && !drv_busy) begin
                    w_grant    = 1'b1;
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion takes priority over the terminal count.
                if (drv_done) begin
                    w_to_guard = 1'b1;
                    w_state_nx = S_GUARD;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_timeout  = 1'b1;
                    w_to_guard = 1'b1;
                    w_state_nx = S_GUARD;
                end
            end
            S_GUARD: begin
                if (r_gcnt == GRD_LAST) begin
                    w_to_idle  = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // NOTE: this block holds only flops, no memories, so every register is
    // reset; a mid-operation reset therefore discards all pending work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_d     <= '0;
            r_pending   <= '0;
            r_drop_cnt  <= '0;
            r_rr_ptr    <= RR_INIT;
            r_cmd_ch    <= '0;
            r_cmd_start <= 1'b0;
            r_ena       <= 1'b0;
            r_err       <= 1'b0;
            r_tmo_cnt   <= '0;
            r_gcnt      <= '0;
        end else begin
            r_req_d     <= req;
            // Set wins over clear when both hit the same bit.
            r_pending   <= (r_pending & ~w_clr) | w_edge;
            r_drop_cnt  <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            r_cmd_start <= w_grant;
            r_err       <= w_timeout;

            if (w_grant) begin
                r_cmd_ch  <= w_sel;
                r_rr_ptr  <= w_sel;
                r_ena     <= 1'b1;
                r_tmo_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end

            if (w_to_idle) begin
                r_ena <= 1'b0;
            end

            if (w_to_guard) begin
                r_gcnt <= '0;
            end else if (r_state == S_GUARD) begin
                r_gcnt <= r_gcnt + GW'(1);
            end
        end
    end

    assign cmd_start   = r_cmd_start;
    assign cmd_ch      = r_cmd_ch;
    assign pending     = r_pending;
    assign ena         = r_ena;
    assign err_timeout = r_err;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_comm_switch_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_comm_switch_scheduler
//
// Bench for comm_switch_scheduler. A monitor process samples the DUT 1 ns after
// each rising edge, pops the expected channel from a scoreboard queue on every
// cmd_start, and plays the driver by returning drv_done a programmable number
// of clocks after each start. The main sequence samples 2 ns after each edge,
// so it sees the monitor's bookkeeping for the same cycle.
// -----------------------------------------------------------------------------
module tb_comm_switch_scheduler;

    localparam int N_REQ       = 4;
    localparam int CH_W        = 2;
    localparam int GUARD_CYC   = 20;
    localparam int TIMEOUT_CYC = 1000;

    logic             clk;
    logic             rst;
    logic [N_REQ-1:0] req;
    logic             drv_busy;
    logic             drv_done;
    logic             cmd_start;
    logic [CH_W-1:0]  cmd_ch;
    logic [N_REQ-1:0] pending;
    logic             ena;
    logic             err_timeout;
    logic [7:0]       drop_cnt;

    comm_switch_scheduler #(
        .N_REQ       (N_REQ),
        .CH_W        (CH_W),
        .GUARD_CYC   (GUARD_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .drv_busy    (drv_busy),
        .drv_done    (drv_done),
        .cmd_start   (cmd_start),
        .cmd_ch      (cmd_ch),
        .pending     (pending),
        .ena         (ena),
        .err_timeout (err_timeout),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests    = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int n_starts   = 0;
    int n_err      = 0;
    int start_cyc  = -1;
    int err_cyc    = -1;
    int done_cnt   = 0;
    int done_delay = 0;   // clocks from cmd_start to drv_done sample; 0 = never
    logic [CH_W-1:0] exp_q [$];

    typedef struct {
        logic [N_REQ-1:0]     req;
        int                   n;
        logic [3:0][CH_W-1:0] ord;   // ord[0] is granted first
    } rr_vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && (ena || pending != '0 || exp_q.size() != 0); k++) begin
            tick(1);
        end
        check("drain to idle", (ena || pending != '0 || exp_q.size() != 0) ? 1 : 0, 0);
    endtask

    // Monitor, scoreboard and driver model.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        drv_done = 1'b0;
        if (!rst) begin
            done_cnt = 0;
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) drv_done = 1'b1;
        end
        if (err_timeout) begin
            n_err++;
            err_cyc = cyc;
        end
        if (cmd_start) begin
            n_starts++;
            start_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_start: cmd_ch=%0d with no grant expected", cmd_ch);
            end else begin
                check("grant order cmd_ch", int'(cmd_ch), int'(exp_q.pop_front()));
            end
            if (done_delay == 1) drv_done = 1'b1;
            else if (done_delay > 1) done_cnt = done_delay - 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rr_vec_t vec [5];
        int s, b, ns, ne;

        vec[0] = '{4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
        vec[1] = '{4'b0011, 2, {2'd0, 2'd0, 2'd1, 2'd0}};
        vec[2] = '{4'b1001, 2, {2'd0, 2'd0, 2'd0, 2'd3}};
        vec[3] = '{4'b0110, 2, {2'd0, 2'd0, 2'd2, 2'd1}};
        vec[4] = '{4'b0101, 2, {2'd0, 2'd0, 2'd2, 2'd0}};

        rst      = 1'b0;
        req      = '0;
        drv_busy = 1'b0;
        drv_done = 1'b0;
        tick(3);
        check("reset cmd_start", cmd_start, 0);
        check("reset cmd_ch", cmd_ch, 0);
        check("reset pending", pending, 0);
        check("reset ena", ena, 0);
        check("reset err_timeout", err_timeout, 0);
        check("reset drop_cnt", drop_cnt, 0);
        rst = 1'b1;
        tick(2);

        // Single request with a 5-clock driver; a second request queued during WAIT.
        done_delay = 5;
        exp_q.push_back(2'd2);
        req = 4'b0100;
        tick(1);
        req = '0;
        check("single pending set", pending, 4'b0100);
        check("single no early start", cmd_start, 0);
        tick(1);
        check("single start latency", cmd_start, 1);
        check("single ena rise", ena, 1);
        check("single pending clear", pending, 0);
        s = cyc;
        exp_q.push_back(2'd1);
        req = 4'b0010;
        tick(1);
        req = '0;
        for (int k = 0; k < 200 && ena; k++) tick(1);
        check("single ena width", cyc - s, 5 + GUARD_CYC);
        check("pending held through guard", pending, 4'b0010);
        ns = n_starts;
        for (int k = 0; k < 50 && n_starts == ns; k++) tick(1);
        check("single next start gap", start_cyc - s, 5 + GUARD_CYC + 1);
        drain(300);
        check("single no timeout", n_err, 0);

        // Reset so the round-robin pointer starts at N_REQ-1.
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);

        // Round-robin table; the pointer carries over from one entry to the next.
        done_delay = 3;
        for (int v = 0; v < 5; v++) begin
            ns = n_starts;
            for (int j = 0; j < vec[v].n; j++) exp_q.push_back(vec[v].ord[j]);
            req = vec[v].req;
            tick(1);
            req = '0;
            drain(500);
            check("rr grant count", n_starts - ns, vec[v].n);
        end

        // Timeout on channel 3, with channel 0 queued behind it.
        done_delay = 0;
        exp_q.push_back(2'd3);
        req = 4'b1000;
        tick(1);
        req = '0;
        tick(1);
        s = start_cyc;
        exp_q.push_back(2'd0);
        req = 4'b0001;
        tick(1);
        req = '0;
        ne = n_err;
        for (int k = 0; k < 1100 && n_err == ne; k++) tick(1);
        check("timeout latency", err_cyc - s, TIMEOUT_CYC);
        check("timeout strobe high", err_timeout, 1);
        done_delay = 3;
        ns = n_starts;
        tick(1);
        check("timeout strobe one clock", err_timeout, 0);
        check("timeout enters guard", ena, 1);
        for (int k = 0; k < 100 && n_starts == ns; k++) tick(1);
        check("timeout next start gap", start_cyc - err_cyc, GUARD_CYC + 1);
        drain(300);

        // drv_done on the terminal count: completion wins, no error.
        done_delay = TIMEOUT_CYC;
        ne = n_err;
        exp_q.push_back(2'd1);
        req = 4'b0010;
        tick(1);
        req = '0;
        tick(1);
        s = start_cyc;
        for (int k = 0; k < 1200 && ena; k++) tick(1);
        check("terminal done no error", n_err - ne, 0);
        check("terminal done ena span", cyc - s, TIMEOUT_CYC + GUARD_CYC);
        drain(300);

        // Merge while busy, then an edge on the very cycle the bit is granted.
        done_delay = 3;
        drv_busy = 1'b1;
        ns = n_starts;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        repeat (3) begin
            req = 4'b0010;
            tick(1);
            req = '0;
            tick(1);
        end
        check("merge drop_cnt", drop_cnt, 2);
        check("merge pending", pending, 4'b0010);
        drv_busy = 1'b0;
        req = 4'b0010;
        tick(1);
        req = '0;
        check("set-wins start", cmd_start, 1);
        check("set-wins pending kept", pending, 4'b0010);
        check("set-wins not a drop", drop_cnt, 2);
        drain(300);
        check("merge grant count", n_starts - ns, 2);

        // drv_busy held for 50 clocks.
        drv_busy = 1'b1;
        ns = n_starts;
        exp_q.push_back(2'd2);
        req = 4'b0100;
        tick(1);
        req = '0;
        tick(50);
        check("busy no start", n_starts - ns, 0);
        check("busy pending kept", pending, 4'b0100);
        drv_busy = 1'b0;
        b = cyc;
        for (int k = 0; k < 10 && n_starts == ns; k++) tick(1);
        check("busy release latency", start_cyc - b, 1);
        drain(300);

        // Reset in the middle of WAIT with pending=1010.
        done_delay = 0;
        ns = n_starts;
        exp_q.push_back(2'd2);
        req = 4'b0100;
        tick(1);
        req = '0;
        tick(1);
        check("rst test grant", n_starts - ns, 1);
        req = 4'b1010;
        tick(1);
        req = '0;
        tick(1);
        check("pending before reset", pending, 4'b1010);
        rst = 1'b0;
        #1;
        check("mid reset cmd_ch", cmd_ch, 0);
        check("mid reset pending", pending, 0);
        check("mid reset ena", ena, 0);
        check("mid reset err_timeout", err_timeout, 0);
        check("mid reset drop_cnt", drop_cnt, 0);
        check("mid reset cmd_start", cmd_start, 0);
        tick(2);
        rst = 1'b1;
        ns = n_starts;
        tick(30);
        check("no start after release", n_starts - ns, 0);
        check("pending lost after reset", pending, 0);
        done_delay = 3;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        req = 4'b1001;
        tick(1);
        req = '0;
        drain(300);
        check("post-reset grant count", n_starts - ns, 2);

        check("scoreboard empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/comm_switch_scheduler.md
# comm_switch_scheduler

Shares one commutator switch driver between several commutator timing channels. Each channel raises a request when its switching interval expires. The block latches and queues those requests, then grants them one at a time in round-robin order. It issues a start command to the driver, waits for completion or timeout, and enforces a guard gap before the next command.

## Interface
Parameters:
- N_REQ, 4, number of requesting channels (2..8)
- CH_W, 2, channel index width, ≥ clog2(N_REQ)
- GUARD_CYC, 20, idle clocks between driver commands (≥1)
- TIMEOUT_CYC, 1000, clocks to wait for drv_done before error (≥2)

Ports:
- clk  in  1  system clock (80 MHz)
- rst  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-channel request, synchronous to clk; rising edge = one request
- drv_busy  in  1  driver not ready; level
- drv_done  in  1  driver completion strobe, one clock
- cmd_start  out  1  one-clock start strobe to driver
- cmd_ch  out  CH_W  channel of current/last command; stable from cmd_start until next cmd_start
- pending  out  N_REQ  latched, not-yet-granted requests
- ena  out  1  high from cmd_start until GUARD exits
- err_timeout  out  1  one-clock strobe on driver timeout
- drop_cnt  out  8  saturating count of requests merged into an already-pending bit

## Operation
- Edge detect: req_d registered each clock. Edge on bit i when req[i] & ~req_d[i].
- pending[i] is set on edge i. It is cleared when channel i is granted. If set and clear occur in the same cycle, set wins and pending stays 1.
- An edge on a bit already pending, and not being cleared that cycle, increments drop_cnt. drop_cnt saturates at 255.
- Round robin: rr_ptr holds the last granted channel; reset value is N_REQ-1, so channel 0 has first priority. The search starts at rr_ptr+1, wraps modulo N_REQ, and takes the first set pending bit.
- FSM states: IDLE, WAIT, GUARD.
  - IDLE: when |pending && !drv_busy, grant the selected channel k:
    - cmd_start=1 for one clock; cmd_ch=k; rr_ptr=k; clear pending[k]; ena=1; tmo_cnt=0; go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT: tmo_cnt increments each clock.
    - drv_done=1: go to GUARD with gcnt=0.
    - Else if tmo_cnt==TIMEOUT_CYC-1: err_timeout=1 for one clock, go to GUARD with gcnt=0.
    - If drv_done coincides with the terminal count, done wins and no error is raised.
  - GUARD: gcnt increments. At gcnt==GUARD_CYC-1, set ena=0 and go to IDLE.
- drv_done outside WAIT is ignored. drv_busy is only sampled in IDLE.
- Requests keep latching in every state.

## Timing
- Reset values: cmd_start=0, cmd_ch=0, pending=0, ena=0, err_timeout=0, drop_cnt=0. Internal: state=IDLE, rr_ptr=N_REQ-1, req_d=0, counters 0.
- Reset applied mid-operation returns everything to reset values immediately. Pending requests are lost, and no strobe is emitted on release.
- Latency, with edge sampled at clock edge t:
  - pending[i]=1 after t.
  - cmd_start=1 after t+1, if IDLE and !drv_busy.
  - Minimum request-to-start is 2 clocks.
- cmd_start, pending clear and ena rise occur on the same edge.
- drv_done sampled at edge u: GUARD is entered at u. The next earliest cmd_start is after edge u+GUARD_CYC+1, giving a gap of GUARD_CYC clocks in GUARD plus one IDLE decision clock.
- Timeout: cmd_start at edge s with no drv_done gives err_timeout high after edge s+TIMEOUT_CYC.
- All outputs are registered. No combinational input-to-output paths.

## Test plan
- Single request: pulse req[2] for one clock, drv_done 5 clocks after cmd_start. Required: cmd_start exactly 2 clocks after the req sample, cmd_ch=2, pending returns to 0, ena high for 5+GUARD_CYC clocks, next cmd_start no earlier than GUARD_CYC+1 clocks after done.
- Round robin: raise req[3:0]=1111 in the same clock, answer each command with drv_done after 3 clocks. Required: grant order 0,1,2,3. Then pulse req[0] and req[1] together after the last grant (rr_ptr=3). Required: order 0,1.
- Timeout: one request with drv_done never asserted, TIMEOUT_CYC=1000. Required: err_timeout high for one clock exactly 1000 clocks after cmd_start, then GUARD, then the next pending request is served. Separately, drv_done on the terminal cycle gives no err_timeout.
- Merge/drop: pulse req[1] three times while channel 1 is pending and the driver is busy. Required: one grant for channel 1, drop_cnt=2. Also a req[1] edge in the cycle pending[1] is cleared: pending[1] stays 1 and a second grant follows.
- drv_busy hold: pending set with drv_busy=1 for 50 clocks. Required: no cmd_start until the clock after drv_busy falls, and pending is preserved.
- Reset mid-WAIT: assert rst during WAIT with pending=1010. Required: all outputs 0 immediately. After release, no cmd_start until a new req edge, and the first grant goes to channel 0 priority.
